// File: rtl/answer_serializer.sv
// answer_serializer: captures a packed answer and streams one byte per field, highest field first.
// Optional build macro PKG_TERMINATOR_EN appends a fixed 0x0A byte after field 0.
module answer_serializer #(
   parameter int         NUM_FIELDS = 30,
   parameter int         FIELD_W    = 5,
   parameter logic [7:0] OFFSET     = 8'd0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_FIELDS*FIELD_W-1:0]   answer_in,
   input  logic                            load,
   output logic [7:0]                      byte_out,
   output logic                            byte_valid,
   input  logic                            byte_ready,
   output logic                            busy,
   output logic                            done
);
   // state | meaning
   // IDLE  | waiting for load; outputs quiet
   // SEND  | presenting field[idx] + OFFSET until accepted
   // TERM  | presenting the 0x0A terminator (PKG_TERMINATOR_EN builds only)
   // DONE  | one-cycle done pulse, then back to IDLE

   localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FIELDS - 1);

`ifdef PKG_TERMINATOR_EN
   typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

   state_t                          state;
   logic [IDX_W-1:0]                idx;
   logic [NUM_FIELDS*FIELD_W-1:0]   shadow;

   // Zero-pad the field to a byte and add OFFSET; the carry out of bit 7 is dropped.
   function automatic logic [7:0] field_byte(input logic [NUM_FIELDS*FIELD_W-1:0] vec,
                                             input logic [IDX_W-1:0] sel);
      logic [FIELD_W-1:0] fld;
      fld = vec[int'(sel)*FIELD_W +: FIELD_W];
      return 8'(fld) + OFFSET;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         shadow     <= '0;
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  shadow     <= answer_in;
                  idx        <= IDX_LAST;
                  byte_out   <= field_byte(answer_in, IDX_LAST);
                  byte_valid <= 1'b1;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (byte_ready) begin
                  if (idx != '0) begin
                     idx      <= idx - IDX_W'(1);
                     byte_out <= field_byte(shadow, idx - IDX_W'(1));
                  end else begin
`ifdef PKG_TERMINATOR_EN
                     byte_out   <= 8'h0A;
                     state      <= TERM;
`else
                     byte_out   <= 8'h00;
                     byte_valid <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
`endif
                  end
               end
            end
`ifdef PKG_TERMINATOR_EN
            TERM: begin
               if (byte_ready) begin
                  byte_out   <= 8'h00;
                  byte_valid <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
`endif
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               byte_out   <= 8'h00;
               byte_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
